im_loader: RTL and testbench
============================

# im_loader

Boot-time loader that fills the writable instruction memory from a byte stream before the single-cycle CPU runs. It accepts bytes over a valid/ready handshake and packs them big-endian into 32-bit instructions. It writes them to consecutive word addresses from 0, then zero-fills the rest of the memory. It holds the CPU in a stall for the whole load and flags malformed streams.

## Interface
- DEPTH, 64, instruction memory depth in words (power of two).
- ADDR_W, 6, word-address width, log2(DEPTH).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in is valid.
- byte_last  in  1  qualifies byte_in as the final byte of the program.
- byte_ready  out  1  loader accepts a byte this cycle.
- im_we  out  1  instruction memory write enable.
- im_addr  out  ADDR_W  word address, equal to PC[ADDR_W+1:2] on the fetch side.
- im_wdata  out  32  instruction word.
- word_count  out  ADDR_W+1  number of program words written (fill words excluded).
- cpu_hold  out  1  stalls CPU PC update while high.
- busy  out  1  a load is in progress.
- done  out  1  load finished; stays high until the next start.
- err  out  1  malformed stream (last not on a word boundary, or program longer than DEPTH); sticky until the next start.

## Operation
- States: IDLE, LOAD, WRITE, FILL, DONE.
- IDLE: byte_ready=0, cpu_hold=0. On start, go to LOAD and clear the byte counter, word_count, addr, err and done.
- LOAD: byte_ready=1. A byte transfers when byte_valid && byte_ready. Shift the word register left by 8 and insert byte_in (first byte lands in [31:24]). Increment the 2-bit byte counter.
- On the 4th byte, go to WRITE and latch byte_last into last_q.
- byte_last on byte 1–3 is an error: set err, drop the partial word, go to DONE with no fill.
- WRITE (1 cycle): im_we=1, im_addr=addr, im_wdata=word; word_count+1.
  - last_q=1: if addr==DEPTH-1 go to DONE, else addr+1 and go to FILL.
  - last_q=0: if addr==DEPTH-1, set err and go to DONE (overflow; no further bytes accepted). Otherwise addr+1 and return to LOAD.
- FILL: im_we=1, im_wdata=0, one address per cycle. When addr==DEPTH-1 is written, go to DONE; otherwise increment addr.
- DONE: done=1, cpu_hold=0, byte_ready=0. start re-enters LOAD as from IDLE.
- busy=1 and cpu_hold=1 in LOAD, WRITE and FILL.
- start in LOAD/WRITE/FILL is ignored. byte_valid outside LOAD is ignored.
- word_count saturates at DEPTH; addr never wraps.

## Timing
- Reset values, applied asynchronously: state=IDLE; byte_ready=0, im_we=0, im_addr=0, im_wdata=0, word_count=0, cpu_hold=0, busy=0, done=0, err=0.
- All outputs are functions of registered state only; no combinational input-to-output paths (byte_ready does not depend on byte_valid).
- Write latency: 4th byte accepted at edge k, so im_we is high in cycle k+1 and memory captures the word at edge k+1.
- Minimum 5 cycles per word with continuous valid.
- FILL after a program of N words (N<DEPTH) takes DEPTH−N cycles. done rises the cycle after the final write.
- Reset mid-load: im_we drops immediately; memory keeps whatever was written; state returns to IDLE.

## Structure
- Package im_loader_pkg holds:
  - state enum (IDLE, LOAD, WRITE, FILL, DONE);
  - DEPTH and ADDR_W defaults;
  - WORD_BYTES=4.
- Sub-module word_assembler: shift register plus byte counter with clear/shift inputs. It produces word, word_full and last_q. The FSM and address/fill logic stay in im_loader.

## Test plan
- Two-word load, bytes 20 08 00 20 / 20 09 00 37 with last on byte 8:
  - writes 0x20080020@0 and 0x20090037@1, then zeros @2..63 (62 FILL cycles);
  - word_count=2, done=1, err=0.
- Full 64-word load with last on byte 256: 64 writes, no FILL cycles, done=1, err=0.
- 65th word (no last by byte 256): err=1 after the write @63, byte_ready=0 thereafter, no 65th write.
- last on byte 6 of a stream: only word 0 written, err=1, done=1, word_count=1, no fill.
- Gapped byte_valid (1 of 3 cycles) with start pulsed mid-load: data is unchanged from the gap-free case and the start is ignored.
- rst_n low during FILL at addr 10: im_we=0 and all outputs at reset values within the same cycle. A subsequent start reloads from address 0.

Source files
------------

// File: rtl/im_loader_pkg.sv
// rtl/im_loader_pkg.sv - shared types and default sizes for the instruction memory loader
package im_loader_pkg;

    localparam int DEFAULT_DEPTH  = 64;
    localparam int DEFAULT_ADDR_W = 6;
    localparam int WORD_BYTES     = 4;
    localparam int BYTE_CNT_W     = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        FILL  = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/im_loader_word_assembler.sv
// rtl/im_loader_word_assembler.sv - big-endian byte-to-word shift register with byte counter
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear_i      restart assembly (counter, word and last flag to zero)
//   shift_i      accept byte_i this cycle
//   byte_i       incoming byte, first byte of a word ends up in [31:24]
//   last_i       last flag of the incoming byte, captured on the 4th byte
//   word_o       assembled word
//   word_full_o  the byte shifted this cycle completes the word
//   last_o       last flag captured with the most recent complete word
module word_assembler
    import im_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    input  logic        last_i,
    output logic [31:0] word_o,
    output logic        word_full_o,
    output logic        last_o
);

    localparam logic [BYTE_CNT_W-1:0] CNT_MAX = BYTE_CNT_W'(WORD_BYTES - 1);

    logic [31:0]           word_q;
    logic [BYTE_CNT_W-1:0] cnt_q;
    logic                  last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else if (clear_i) begin
            word_q <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else if (shift_i) begin
            word_q <= {word_q[23:0], byte_i};
            // Counter wraps to zero after the 4th byte, ready for the next word.
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CNT_MAX) begin
                last_q <= last_i;
            end
        end
    end

    assign word_o      = word_q;
    assign word_full_o = shift_i && (cnt_q == CNT_MAX);
    assign last_o      = last_q;

endmodule

// File: rtl/im_loader.sv
// rtl/im_loader.sv - boot loader filling instruction memory from a byte stream, then zero-filling
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a load (honoured in IDLE or DONE only)
//   byte_in/valid/last/ready   byte stream handshake, big-endian packing
//   im_we/addr/wdata  instruction memory write port
//   word_count        program words written (fill excluded), saturates at DEPTH
//   cpu_hold, busy    high while loading, writing or filling
//   done              load finished, held until next start
//   err               malformed stream, sticky until next start
module im_loader
    import im_loader_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   WC_MAX    = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic              err_q, err_d;

    logic        clear;
    logic        shift;
    logic [31:0] word;
    logic        word_full;
    logic        last_q;

    // Kept outside the FSM process so word_full (which depends on shift)
    // does not loop back into the block that produces shift.
    assign clear = start && ((state_q == IDLE) || (state_q == DONE));
    assign shift = (state_q == LOAD) && byte_valid;

    word_assembler u_word_assembler (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear),
        .shift_i     (shift),
        .byte_i      (byte_in),
        .last_i      (byte_last),
        .word_o      (word),
        .word_full_o (word_full),
        .last_o      (last_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wc_q    <= wc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wc_d    = wc_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    wc_d    = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (shift) begin
                    if (word_full) begin
                        state_d = WRITE;
                    end else if (byte_last) begin
                        // Last byte mid-word: partial word is discarded, no fill.
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                if (wc_q != WC_MAX) begin
                    wc_d = wc_q + 1'b1;
                end
                if (addr_q == LAST_ADDR) begin
                    // Memory full: a missing last flag means the program overflows.
                    state_d = DONE;
                    if (!last_q) begin
                        err_d = 1'b1;
                    end
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = last_q ? FILL : LOAD;
                end
            end
            FILL: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign byte_ready = (state_q == LOAD);
    assign im_we      = (state_q == WRITE) || (state_q == FILL);
    assign im_addr    = addr_q;
    assign im_wdata   = (state_q == WRITE) ? word : 32'h0;
    assign word_count = wc_q;
    assign busy       = (state_q == LOAD) || (state_q == WRITE) || (state_q == FILL);
    assign cpu_hold   = busy;
    assign done       = (state_q == DONE);
    assign err        = err_q;

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - scoreboard testbench for im_loader
module tb_im_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_last;
    logic              byte_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic [ADDR_W:0]   word_count;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t        sb[$];
    logic [7:0] stream[$];
    int         checks;
    int         errors;
    int         nwrites;

    im_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .word_count (word_count),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every memory write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && im_we) begin
            wr_t exp;
            nwrites++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr=%0d data=%08h, required no write", im_addr, im_wdata);
            end else begin
                exp = sb.pop_front();
                if (im_addr !== exp.addr || im_wdata !== exp.data) begin
                    errors++;
                    $display("FAIL write_data: got addr=%0d data=%08h, required addr=%0d data=%08h",
                             im_addr, im_wdata, exp.addr, exp.data);
                end
            end
        end
    end

    task automatic push_write(input int a, input logic [31:0] d);
        wr_t w;
        w.addr = ADDR_W'(a);
        w.data = d;
        sb.push_back(w);
    endtask

    // Expected writes for the bytes in stream: full words then zero fill to the end.
    task automatic push_program(input int nwords, input bit fill);
        for (int w = 0; w < nwords; w++) begin
            push_write(w, {stream[4*w], stream[4*w+1], stream[4*w+2], stream[4*w+3]});
        end
        if (fill) begin
            for (int a = nwords; a < DEPTH; a++) push_write(a, 32'h0);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drive one byte and hold it until accepted; called at posedge+1.
    task automatic send_byte(input logic [7:0] b, input logic last);
        logic rdy;
        int   n;
        byte_in    = b;
        byte_last  = last;
        byte_valid = 1'b1;
        n = 0;
        do begin
            rdy = byte_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 20);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %02h not accepted, required accept within 20 cycles", b);
        end
    endtask

    // gap: idle cycles before each byte; start_at: byte index before which start is pulsed.
    task automatic send_stream(input int last_pos, input int gap, input int start_at);
        for (int i = 0; i < stream.size(); i++) begin
            for (int g = 0; g < gap; g++) begin
                if (i == start_at && g == 0) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            send_byte(stream[i], (i + 1) == last_pos);
        end
    endtask

    task automatic wait_done(input string name, input logic exp_err, input int exp_wc);
        int n = 0;
        while (!done && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: got done=%b, required 1 within 500 cycles", name, done);
        end
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL %s_err: got %b, required %b", name, err, exp_err);
        end
        checks++;
        if (word_count !== (ADDR_W + 1)'(exp_wc)) begin
            errors++;
            $display("FAIL %s_word_count: got %0d, required %0d", name, word_count, exp_wc);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_writes: got %0d writes outstanding, required 0", name, sb.size());
        end
        checks++;
        if (busy !== 1'b0 || cpu_hold !== 1'b0 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_flags: got busy=%b hold=%b ready=%b, required 0 0 0",
                     name, busy, cpu_hold, byte_ready);
        end
    endtask

    task automatic load_two_word_stream();
        stream.delete();
        stream.push_back(8'h20); stream.push_back(8'h08); stream.push_back(8'h00); stream.push_back(8'h20);
        stream.push_back(8'h20); stream.push_back(8'h09); stream.push_back(8'h00); stream.push_back(8'h37);
    endtask

    task automatic test_reset();
        checks++;
        if ({byte_ready, im_we, im_addr, im_wdata, word_count, cpu_hold, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b we=%b addr=%0d wdata=%08h wc=%0d hold=%b busy=%b done=%b err=%b, required all 0",
                     byte_ready, im_we, im_addr, im_wdata, word_count, cpu_hold, busy, done, err);
        end
    endtask

    task automatic test_two_word();
        load_two_word_stream();
        sb.delete();
        push_write(0, 32'h20080020);
        push_write(1, 32'h20090037);
        for (int a = 2; a < DEPTH; a++) push_write(a, 32'h0);
        nwrites = 0;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || cpu_hold !== 1'b1 || byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL two_word_load_flags: got busy=%b hold=%b ready=%b, required 1 1 1", busy, cpu_hold, byte_ready);
        end
        send_stream(8, 0, -1);
        wait_done("two_word", 1'b0, 2);
        checks++;
        if (nwrites != DEPTH) begin
            errors++;
            $display("FAIL two_word_write_count: got %0d, required %0d", nwrites, DEPTH);
        end
    endtask

    task automatic test_full();
        stream.delete();
        for (int i = 0; i < 4 * DEPTH; i++) stream.push_back(8'($urandom));
        sb.delete();
        push_program(DEPTH, 1'b0);
        pulse_start();
        send_stream(4 * DEPTH, 0, -1);
        wait_done("full", 1'b0, DEPTH);
    endtask

    task automatic test_overflow();
        stream.delete();
        for (int i = 0; i < 4 * DEPTH; i++) stream.push_back(8'($urandom));
        sb.delete();
        push_program(DEPTH, 1'b0);
        pulse_start();
        send_stream(-1, 0, -1);
        wait_done("overflow", 1'b1, DEPTH);
        // Further bytes must be refused and produce no write.
        byte_in    = 8'hA5;
        byte_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (byte_ready !== 1'b0) begin
                errors++;
                $display("FAIL overflow_ready: got %b, required 0", byte_ready);
            end
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_early_last();
        stream.delete();
        for (int i = 0; i < 6; i++) stream.push_back(8'(8'h11 * (i + 1)));
        sb.delete();
        push_write(0, 32'h11223344);
        pulse_start();
        send_stream(6, 0, -1);
        wait_done("early_last", 1'b1, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_gapped();
        load_two_word_stream();
        sb.delete();
        push_program(2, 1'b1);
        pulse_start();
        send_stream(8, 2, 3);
        wait_done("gapped", 1'b0, 2);
    endtask

    task automatic test_reset_fill();
        int n = 0;
        load_two_word_stream();
        sb.delete();
        push_program(2, 1'b1);
        pulse_start();
        send_stream(8, 0, -1);
        while (!(im_we && im_addr == ADDR_W'(10)) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!(im_we && im_addr == ADDR_W'(10))) begin
            errors++;
            $display("FAIL rst_fill_reach: got we=%b addr=%0d, required fill at addr 10", im_we, im_addr);
        end
        rst_n = 1'b0;
        #1;
        test_reset();
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        // Reload a single word and confirm addressing restarts at 0.
        stream.delete();
        stream.push_back(8'hDE); stream.push_back(8'hAD); stream.push_back(8'hBE); stream.push_back(8'hEF);
        push_write(0, 32'hDEADBEEF);
        for (int a = 1; a < DEPTH; a++) push_write(a, 32'h0);
        pulse_start();
        send_stream(4, 0, -1);
        wait_done("reload", 1'b0, 1);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        nwrites    = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h0;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_two_word();
        test_full();
        test_overflow();
        test_early_last();
        test_gapped();
        test_reset_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
